// File: rtl/sysid_checker_pkg.sv
// rtl/sysid_checker_pkg.sv - shared types and constants for the system ID checker
// Contents: FSM state encoding, slave word addresses, wait-counter width.
package sysid_checker_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_ID = 3'd1,
    S_RD_TS = 3'd2,
    S_CMP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam int WAIT_CNT_W = 16;

endpackage

// File: rtl/sysid_checker_if.sv
// rtl/sysid_checker_if.sv - Avalon-MM read bus between checker and system ID slave
// Signals: avm_address (word address), avm_read (strobe),
//          avm_waitrequest (slave stall), avm_readdata (32-bit read data).
// Modports: master (checker side), slave (system ID side).
interface sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/sysid_checker_timer.sv
// rtl/sysid_checker_timer.sv - clearable up-counter with terminal-count flag
// Ports: i_clock, i_reset (sync, active-high), i_clear (load zero),
//        i_en (count up), o_tc (count equals TERMINAL).
module sysid_checker_timer #(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] TERMINAL = '1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  logic [WIDTH-1:0] r_count;

  // Clear has priority so a state entry always restarts the count at zero.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_tc = (r_count == TERMINAL);

endmodule

// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - reads system ID and build timestamp, reports pass/fail
// Optional feature: SYSID_CHECK_PERIODIC_EN adds RECHECK_PERIOD and a periodic relaunch from DONE.
// Ports: i_clock, i_reset (sync, active-high), i_start (launch pulse),
//        avm (Avalon-MM read master), o_busy, o_done, o_id_ok, o_ts_ok,
//        o_timeout, o_id_value, o_ts_value (all registered).
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1394485293,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter bit          AUTO_START     = 1'b1
`ifdef SYSID_CHECK_PERIODIC_EN
  ,
  parameter int unsigned RECHECK_PERIOD = 50_000_000
`endif
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  sysid_checker_if.master       avm,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_id_ok,
  output logic                  o_ts_ok,
  output logic                  o_timeout,
  output logic [31:0]           o_id_value,
  output logic [31:0]           o_ts_value
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_TERMINAL = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_state;
  logic        r_read, w_read;
  logic        r_addr, w_addr;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        r_id_ok, w_id_ok;
  logic        r_ts_ok, w_ts_ok;
  logic        r_timeout, w_timeout;
  logic [31:0] r_id_value, w_id_value;
  logic [31:0] r_ts_value, w_ts_value;
  logic        r_auto_pend;
  logic        w_wait_tc;
  logic        w_period_tc;
  logic        w_launch;

  // Wait counter restarts on every state entry and only advances while a
  // read strobe is stalled, so its terminal count marks a per-read timeout.
  sysid_checker_timer #(
    .WIDTH    (WAIT_CNT_W),
    .TERMINAL (WAIT_TERMINAL)
  ) u_wait_timer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (w_state != r_state),
    .i_en    (r_read && avm.avm_waitrequest),
    .o_tc    (w_wait_tc)
  );

`ifdef SYSID_CHECK_PERIODIC_EN
  sysid_checker_timer #(
    .WIDTH    (32),
    .TERMINAL (32'(RECHECK_PERIOD - 1))
  ) u_period_timer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (r_state != S_DONE),
    .i_en    (r_state == S_DONE),
    .o_tc    (w_period_tc)
  );
`else
  assign w_period_tc = 1'b0;
`endif

  // r_auto_pend is high only in the first cycle after reset releases, which
  // makes the auto launch behave exactly like a start pulse in that cycle.
  always_comb begin
    w_launch = ((r_state == S_IDLE) && (i_start || r_auto_pend)) ||
               ((r_state == S_DONE) && (i_start || w_period_tc));
  end

  always_comb begin
    w_state    = r_state;
    w_read     = r_read;
    w_addr     = r_addr;
    w_busy     = r_busy;
    w_done     = r_done;
    w_id_ok    = r_id_ok;
    w_ts_ok    = r_ts_ok;
    w_timeout  = r_timeout;
    w_id_value = r_id_value;
    w_ts_value = r_ts_value;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_launch) begin
          w_state   = S_RD_ID;
          w_read    = 1'b1;
          w_addr    = ADDR_ID;
          w_busy    = 1'b1;
          w_done    = 1'b0;
          w_id_ok   = 1'b0;
          w_ts_ok   = 1'b0;
          w_timeout = 1'b0;
        end
      end
      S_RD_ID, S_RD_TS: begin
        // Completion is checked first so it wins over a same-cycle timeout.
        if (!avm.avm_waitrequest) begin
          if (r_state == S_RD_ID) begin
            w_id_value = avm.avm_readdata;
            w_addr     = ADDR_TS;
            w_state    = S_RD_TS;
          end else begin
            w_ts_value = avm.avm_readdata;
            w_read     = 1'b0;
            w_state    = S_CMP;
          end
        end else if (w_wait_tc) begin
          w_read    = 1'b0;
          w_timeout = 1'b1;
          w_id_ok   = 1'b0;
          w_ts_ok   = 1'b0;
          w_busy    = 1'b0;
          w_done    = 1'b1;
          w_state   = S_DONE;
        end
      end
      S_CMP: begin
        w_id_ok = (r_id_value == EXPECTED_ID);
        w_ts_ok = (r_ts_value == EXPECTED_TS);
        w_busy  = 1'b0;
        w_done  = 1'b1;
        w_state = S_DONE;
      end
      default: begin
        w_state = S_IDLE;
        w_read  = 1'b0;
        w_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_read      <= 1'b0;
      r_addr      <= ADDR_ID;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_id_ok     <= 1'b0;
      r_ts_ok     <= 1'b0;
      r_timeout   <= 1'b0;
      r_id_value  <= '0;
      r_ts_value  <= '0;
      r_auto_pend <= AUTO_START;
    end else begin
      r_state     <= w_state;
      r_read      <= w_read;
      r_addr      <= w_addr;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_id_ok     <= w_id_ok;
      r_ts_ok     <= w_ts_ok;
      r_timeout   <= w_timeout;
      r_id_value  <= w_id_value;
      r_ts_value  <= w_ts_value;
      r_auto_pend <= 1'b0;
    end
  end

  assign avm.avm_read    = r_read;
  assign avm.avm_address = r_addr;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_id_ok         = r_id_ok;
  assign o_ts_ok         = r_ts_ok;
  assign o_timeout       = r_timeout;
  assign o_id_value      = r_id_value;
  assign o_ts_value      = r_ts_value;

endmodule

// File: tb/tb_sysid_checker.sv
// tb/tb_sysid_checker.sv - directed self-checking bench for sysid_checker
module tb_sysid_checker;

  localparam logic [31:0] GOOD_TS = 32'd1394485293;
  localparam logic [31:0] BAD_TS  = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  logic [31:0] id_data;
  logic [31:0] ts_data;
  int          stall_cfg = 0;
  int          stall_cnt = 0;

  int n_vec = 0;
  int n_err = 0;

  sysid_checker_if bus ();

  always #5 clk = ~clk;

  // Slave model: stalls each read for stall_cfg cycles, then completes.
  assign bus.avm_waitrequest = bus.avm_read && (stall_cnt < stall_cfg);
  assign bus.avm_readdata    = bus.avm_address ? ts_data : id_data;

  always @(posedge clk) begin
    if (!bus.avm_read || !bus.avm_waitrequest) stall_cnt <= 0;
    else stall_cnt <= stall_cnt + 1;
  end

  sysid_checker #(
    .EXPECTED_ID    (32'h0000_0000),
    .EXPECTED_TS    (GOOD_TS),
    .TIMEOUT_CYCLES (8),
    .AUTO_START     (1'b1)
`ifdef SYSID_CHECK_PERIODIC_EN
    ,
    .RECHECK_PERIOD (100)
`endif
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_start    (start),
    .avm        (bus),
    .o_busy     (busy),
    .o_done     (done),
    .o_id_ok    (id_ok),
    .o_ts_ok    (ts_ok),
    .o_timeout  (timeout),
    .o_id_value (id_value),
    .o_ts_value (ts_value)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    id_data = 32'h0;
    ts_data = GOOD_TS;
    repeat (3) tick();

    chk("rst_read", 32'(bus.avm_read), 32'd0);
    chk("rst_addr", 32'(bus.avm_address), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
    chk("rst_id_value", id_value, 32'd0);
    chk("rst_ts_value", ts_value, 32'd0);

    // Auto start: RD_ID, RD_TS, CMP, then done four cycles after release.
    rst = 1'b0;
    tick();
    chk("auto_rdid_read", 32'(bus.avm_read), 32'd1);
    chk("auto_rdid_addr", 32'(bus.avm_address), 32'd0);
    chk("auto_rdid_busy", 32'(busy), 32'd1);
    tick();
    chk("auto_rdts_addr", 32'(bus.avm_address), 32'd1);
    chk("auto_rdts_read", 32'(bus.avm_read), 32'd1);
    tick();
    chk("auto_cmp_read", 32'(bus.avm_read), 32'd0);
    chk("auto_cmp_done", 32'(done), 32'd0);
    tick();
    chk("auto_done", 32'(done), 32'd1);
    chk("auto_busy", 32'(busy), 32'd0);
    chk("auto_flags", {29'd0, id_ok, ts_ok, timeout}, 32'b110);
    chk("auto_ts_value", ts_value, GOOD_TS);

    // Wrong timestamp.
    ts_data = BAD_TS;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("bad_launch_done", 32'(done), 32'd0);
    chk("bad_launch_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
    repeat (3) tick();
    chk("bad_done", 32'(done), 32'd1);
    chk("bad_flags", {29'd0, id_ok, ts_ok, timeout}, 32'b100);
    chk("bad_ts_value", ts_value, BAD_TS);

    // Slave fixed, restart passes.
    ts_data = GOOD_TS;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("fix_done", 32'(done), 32'd1);
    chk("fix_flags", {29'd0, id_ok, ts_ok, timeout}, 32'b110);

    // Three wait states per read: strobe/address stable, done six cycles late.
    stall_cfg = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("wait_read", 32'(bus.avm_read), 32'd1);
      chk("wait_addr", 32'(bus.avm_address), (i <= 4) ? 32'd0 : 32'd1);
      if (i < 8) tick();
    end
    tick();
    chk("wait_cmp_done", 32'(done), 32'd0);
    chk("wait_cmp_read", 32'(bus.avm_read), 32'd0);
    tick();
    chk("wait_done", 32'(done), 32'd1);
    chk("wait_flags", {29'd0, id_ok, ts_ok, timeout}, 32'b110);

    // Stuck waitrequest: read held 8 cycles, then timeout.
    stall_cfg = 1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("to_last_read", 32'(bus.avm_read), 32'd1);
    chk("to_last_done", 32'(done), 32'd0);
    tick();
    chk("to_read_drop", 32'(bus.avm_read), 32'd0);
    chk("to_done", 32'(done), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_flags", {29'd0, id_ok, ts_ok, timeout}, 32'b001);
    chk("to_ts_retained", ts_value, GOOD_TS);

    // Start held high while busy must not restart the read sequence.
    stall_cfg = 0;
    start = 1'b1;
    tick();
    tick();
    chk("busy_start_addr", 32'(bus.avm_address), 32'd1);
    chk("busy_start_read", 32'(bus.avm_read), 32'd1);
    tick();
    chk("busy_start_cmp", 32'(bus.avm_read), 32'd0);
    start = 1'b0;
    tick();
    chk("busy_start_done", 32'(done), 32'd1);
    chk("busy_start_flags", {29'd0, id_ok, ts_ok, timeout}, 32'b110);

    // Reset during the second RD_TS cycle.
    id_data = 32'hCAFE_0001;
    stall_cfg = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("mid_addr", 32'(bus.avm_address), 32'd1);
    chk("mid_id_value", id_value, 32'hCAFE_0001);
    rst = 1'b1;
    tick();
    chk("mid_rst_read", 32'(bus.avm_read), 32'd0);
    chk("mid_rst_addr", 32'(bus.avm_address), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_id_value", id_value, 32'd0);
    chk("mid_rst_ts_value", ts_value, 32'd0);
    rst = 1'b0;
    id_data = 32'h0;
    stall_cfg = 0;
    repeat (3) tick();
    chk("relaunch_pre_done", 32'(done), 32'd0);
    tick();
    chk("relaunch_done", 32'(done), 32'd1);
    chk("relaunch_flags", {29'd0, id_ok, ts_ok, timeout}, 32'b110);

`ifdef SYSID_CHECK_PERIODIC_EN
    repeat (99) tick();
    chk("per_before_read", 32'(bus.avm_read), 32'd0);
    chk("per_before_done", 32'(done), 32'd1);
    tick();
    chk("per_read", 32'(bus.avm_read), 32'd1);
    chk("per_addr", 32'(bus.avm_address), 32'd0);
    chk("per_busy", 32'(busy), 32'd1);
    start = 1'b1;
    tick();
    chk("per_busy_start_addr", 32'(bus.avm_address), 32'd1);
    start = 1'b0;
    repeat (2) tick();
    chk("per_done", 32'(done), 32'd1);
    chk("per_flags", {29'd0, id_ok, ts_ok, timeout}, 32'b110);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
- Avalon-MM read master that sits directly downstream of the system ID slave and consumes its two readable words.
- After reset, or on a start pulse, it reads address 0 (system ID) and then address 1 (build timestamp).
- It compares both words against build-time expected values and presents pass/fail status to boot/health logic, e.g. an LED or the CPU reset gate.

Parameters:
- EXPECTED_ID, 32'h0000_0000, value expected at address 0.
- EXPECTED_TS, 32'd1394485293, value expected at address 1.
- TIMEOUT_CYCLES, 256, maximum cycles a single read may stall on waitrequest; range 2..65535.
- AUTO_START, 1, when 1 a check launches automatically on the first cycle after reset deasserts.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; launches a check from IDLE or DONE, ignored while busy.
- avm_address  out  1  slave word address.
- avm_read  out  1  read strobe.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data; valid in any cycle with avm_read=1 and avm_waitrequest=0.
- busy  out  1  check in progress.
- done  out  1  check finished; held until the next start.
- id_ok  out  1  captured ID equals EXPECTED_ID.
- ts_ok  out  1  captured timestamp equals EXPECTED_TS.
- timeout  out  1  a read exceeded TIMEOUT_CYCLES.
- id_value  out  32  last captured ID.
- ts_value  out  32  last captured timestamp.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-high: sampled on the rising edge of clock.
  - Reset mid-transaction drops avm_read in the next cycle with no handshake completion. The check aborts silently.
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0, state=IDLE, wait counter=0.
- States:
  - IDLE: leave on start, or on the first post-reset cycle when AUTO_START=1. On entry to RD_ID, clear done/id_ok/ts_ok/timeout and set busy.
  - RD_ID: drive avm_read=1, avm_address=0.
    - Transfer completes when waitrequest=0: capture id_value, go to RD_TS.
    - avm_read and avm_address are held stable while waitrequest=1.
  - RD_TS: drive avm_read=1, avm_address=1. On completion, capture ts_value and go to CMP.
  - CMP: one cycle. Register id_ok=(id_value==EXPECTED_ID) and ts_ok=(ts_value==EXPECTED_TS). Go to DONE.
  - DONE: busy=0, done=1, flags held. A start pulse re-enters RD_ID.
- Handshake: avm_read deasserts in the cycle after the final completion; there is no idle cycle between RD_ID and RD_TS.
- Timing: with a zero-wait slave, start sampled in cycle N gives RD_ID in N+1, RD_TS in N+2, CMP in N+3, and done=1 in N+4.
- Timeout:
  - A 16-bit wait counter resets on each state entry and increments each cycle waitrequest=1.
  - When it reaches TIMEOUT_CYCLES-1 with waitrequest still high: drop avm_read, set timeout=1, id_ok=0, ts_ok=0, go to DONE.
  - Values already captured are retained.
- Simultaneous events:
  - Completion and the timeout threshold in the same cycle: completion wins.
  - start while busy is ignored.
  - start in the same cycle as reset: reset wins.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro SYSID_CHECK_PERIODIC_EN.
- Defined:
  - Adds parameter RECHECK_PERIOD (default 50_000_000) and a 32-bit free-running counter active while in DONE.
  - When the counter reaches RECHECK_PERIOD-1, the block relaunches the check as if start had pulsed; the counter clears on leaving DONE.
  - Flags stay valid from the previous check until RD_ID entry.
- Undefined: no counter or parameter; the block checks only on reset/AUTO_START and on start.

Decomposition:
- Package sysid_checker_pkg:
  - state enum (IDLE, RD_ID, RD_TS, CMP, DONE).
  - address constants ADDR_ID=1'b0, ADDR_TS=1'b1.
  - wait-counter width constant WAIT_CNT_W=16.
- One natural sub-module, sysid_checker_timer: a loadable wait/period counter with a terminal-count output.
  - Instantiated once for the wait timeout.
  - Instantiated a second time when SYSID_CHECK_PERIODIC_EN is defined.

Test Plan:
- Zero-wait slave returning 0 and 1394485293, AUTO_START=1 → done=1 four cycles after reset release; id_ok=1, ts_ok=1, timeout=0.
- Slave returns 0x12345678 at address 1 → ts_ok=0, id_ok=1, ts_value=0x12345678; start pulse after fixing the slave → ts_ok=1.
- waitrequest high for 3 cycles per read → address/read held stable throughout; done six cycles later than the zero-wait case; flags pass.
- waitrequest stuck high, TIMEOUT_CYCLES=8 → avm_read drops after 8 cycles in RD_ID; timeout=1, id_ok=0, done=1.
- reset asserted in RD_TS cycle 2 → next cycle: avm_read=0, all outputs at reset values; AUTO_START relaunch completes normally.
- With SYSID_CHECK_PERIODIC_EN, RECHECK_PERIOD=100 → a second read pair starts exactly 100 cycles after DONE entry; start pulses while busy are ignored.
